// File: rtl/uart_rx_deser_cfg_if.sv
// Bus between the sampler/receive FSM and the UART receive deserializer.
// The master drives the bit stream and frame config; the slave returns the assembled word.
interface uart_rx_deser_cfg_if #(
  parameter int MAX_WIDTH  = 9,
  parameter int PRESCALE_W = 6,
  parameter int CNT_W      = 4
);
  logic                  sampled_bit;
  logic                  deser_en;
  logic [PRESCALE_W-1:0] prescale;
  logic [PRESCALE_W-1:0] edge_cnt;
  logic [CNT_W-1:0]      data_bits;
  logic                  lsb_first;
  logic [MAX_WIDTH-1:0]  p_data;
  logic                  data_valid;
  logic                  par_calc;
  logic                  busy;
  logic [CNT_W-1:0]      bit_cnt;

  modport master (
    output sampled_bit, deser_en, prescale, edge_cnt, data_bits, lsb_first,
    input  p_data, data_valid, par_calc, busy, bit_cnt
  );

  modport slave (
    input  sampled_bit, deser_en, prescale, edge_cnt, data_bits, lsb_first,
    output p_data, data_valid, par_calc, busy, bit_cnt
  );
endinterface

// File: rtl/uart_rx_deser_cfg.sv
// UART receive deserializer: assembles 1..MAX_WIDTH bits per frame, LSB- or MSB-first,
// and presents a right-justified word with a one-cycle valid strobe and its XOR parity.
//
// state  | meaning
// S_IDLE | no bits captured yet in the current frame
// S_BUSY | frame in progress, at least one bit captured
module uart_rx_deser_cfg #(
  parameter int MAX_WIDTH  = 9,
  parameter int PRESCALE_W = 6,
  parameter int CNT_W      = 4
) (
  input  logic                clk,
  input  logic                rst,
  uart_rx_deser_cfg_if.slave  bus
);

  localparam logic [CNT_W-1:0] MAX_N = CNT_W'(MAX_WIDTH);

  typedef enum logic {S_IDLE, S_BUSY} state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     bit_cnt_q, bit_cnt_d;
  logic [CNT_W-1:0]     nbits_q, cfg_nbits, nbits_eff, idx;
  logic                 lsb_q, lsb_eff;
  logic                 cap, first, last;
  logic [MAX_WIDTH-1:0] shadow_q, shadow_d, p_data_q;
  logic                 par_q, valid_q;

  // Config seen on the first cap of a frame is used directly, then held in nbits_q/lsb_q.
  always_comb begin
    cap       = bus.deser_en && (bus.edge_cnt == bus.prescale - PRESCALE_W'(1));
    cfg_nbits = (bus.data_bits == '0 || bus.data_bits > MAX_N) ? MAX_N : bus.data_bits;
    first     = (bit_cnt_q == '0);
    nbits_eff = first ? cfg_nbits : nbits_q;
    lsb_eff   = first ? bus.lsb_first : lsb_q;
    idx       = lsb_eff ? bit_cnt_q : nbits_eff - CNT_W'(1) - bit_cnt_q;
    shadow_d  = first ? '0 : shadow_q;
    for (int i = 0; i < MAX_WIDTH; i++) begin
      if (CNT_W'(i) == idx) shadow_d[i] = bus.sampled_bit;
    end
    last      = cap && (bit_cnt_q == nbits_eff - CNT_W'(1));
  end

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    if (!bus.deser_en) begin
      state_d   = S_IDLE;
      bit_cnt_d = '0;
    end else if (cap) begin
      if (last) begin
        state_d   = S_IDLE;
        bit_cnt_d = '0;
      end else begin
        state_d   = S_BUSY;
        bit_cnt_d = bit_cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      bit_cnt_q <= '0;
      nbits_q   <= '0;
      lsb_q     <= 1'b0;
      shadow_q  <= '0;
      p_data_q  <= '0;
      par_q     <= 1'b0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      valid_q   <= last;
      if (cap) shadow_q <= shadow_d;
      if (cap && first) begin
        nbits_q <= cfg_nbits;
        lsb_q   <= bus.lsb_first;
      end
      // The completed word includes the bit captured on this same edge.
      if (last) begin
        p_data_q <= shadow_d;
        par_q    <= ^shadow_d;
      end
    end
  end

  assign bus.p_data     = p_data_q;
  assign bus.data_valid = valid_q;
  assign bus.par_calc   = par_q;
  assign bus.busy       = (state_q == S_BUSY);
  assign bus.bit_cnt    = bit_cnt_q;

endmodule

// File: tb/tb_uart_rx_deser_cfg.sv
// Self-checking bench for uart_rx_deser_cfg: directed frames plus a randomized run
// compared against a frame-level reference model built from queues and arithmetic.
module tb_uart_rx_deser_cfg;
  localparam int MW = 9;
  localparam int PW = 6;
  localparam int CW = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_rx_deser_cfg_if #(.MAX_WIDTH(MW), .PRESCALE_W(PW), .CNT_W(CW)) bus ();
  uart_rx_deser_cfg #(.MAX_WIDTH(MW), .PRESCALE_W(PW), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  int n_cmp = 0;
  int n_err = 0;
  int vcount = 0;

  // reference model state
  int       m_q[$];
  int       m_n = 0;
  bit       m_lsb = 1'b0;
  int       m_pdata = 0;
  bit       m_par = 1'b0;
  bit       m_valid = 1'b0;

  // Drive one cycle of inputs, advance the model by the same rules, then wait past the edge.
  task automatic step(input bit r, input bit en, input bit sb, input int ps, input int ec,
                      input int db, input bit lf);
    int w;
    rst             = r;
    bus.deser_en    = en;
    bus.sampled_bit = sb;
    bus.prescale    = PW'(ps);
    bus.edge_cnt    = PW'(ec);
    bus.data_bits   = CW'(db);
    bus.lsb_first   = lf;
    m_valid = 1'b0;
    if (r) begin
      m_q.delete();
      m_pdata = 0;
      m_par   = 1'b0;
    end else if (!en) begin
      m_q.delete();
    end else if (((ps + 63) % 64) == ec) begin
      if (m_q.size() == 0) begin
        m_n   = (db == 0 || db > MW) ? MW : db;
        m_lsb = lf;
      end
      m_q.push_back(int'(sb));
      if (m_q.size() == m_n) begin
        w = 0;
        for (int i = 0; i < m_n; i++)
          w += m_q[i] * (m_lsb ? (1 << i) : (1 << (m_n - 1 - i)));
        m_pdata = w;
        m_par   = bit'($countones(w) % 2);
        m_valid = 1'b1;
        m_q.delete();
      end
    end
    @(posedge clk);
    #1;
    vcount += int'(bus.data_valid);
  endtask

  // One bit period of ps cycles; the cap falls on the last cycle.
  task automatic send_bit(input bit b, input int ps, input int db, input bit lf);
    for (int e = 0; e < ps; e++) step(1'b0, 1'b1, b, ps, e, db, lf);
  endtask

  task automatic test_reset();
    step(1'b1, 1'b0, 1'b0, 8, 0, 8, 1'b1);
    step(1'b1, 1'b0, 1'b0, 8, 0, 8, 1'b1);
    n_cmp++; if (bus.p_data !== 9'h000) begin n_err++; $display("FAIL reset_p_data got %h want 000", bus.p_data); end
    n_cmp++; if (bus.data_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b want 0", bus.data_valid); end
    n_cmp++; if (bus.par_calc !== 1'b0) begin n_err++; $display("FAIL reset_par got %b want 0", bus.par_calc); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", bus.busy); end
    n_cmp++; if (bus.bit_cnt !== 4'd0) begin n_err++; $display("FAIL reset_bit_cnt got %0d want 0", bus.bit_cnt); end
    step(1'b0, 1'b0, 1'b0, 8, 0, 8, 1'b1);
  endtask

  task automatic test_frame8(input bit lf, input logic [8:0] want, input string nm);
    bit bits[8] = '{1, 0, 1, 1, 0, 0, 1, 0};
    int v0 = vcount;
    for (int i = 0; i < 7; i++) send_bit(bits[i], 8, 8, lf);
    n_cmp++; if (vcount != v0) begin n_err++; $display("FAIL %s_early_valid got %0d pulses want 0", nm, vcount - v0); end
    send_bit(bits[7], 8, 8, lf);
    n_cmp++; if (bus.data_valid !== 1'b1) begin n_err++; $display("FAIL %s_valid_at_cap got %b want 1", nm, bus.data_valid); end
    n_cmp++; if (bus.p_data !== want) begin n_err++; $display("FAIL %s_p_data got %h want %h", nm, bus.p_data, want); end
    n_cmp++; if (bus.par_calc !== 1'b0) begin n_err++; $display("FAIL %s_par got %b want 0", nm, bus.par_calc); end
    step(1'b0, 1'b1, 1'b0, 8, 0, 8, lf);
    n_cmp++; if (bus.data_valid !== 1'b0 || bus.busy !== 1'b0) begin n_err++; $display("FAIL %s_after got valid=%b busy=%b want 0 0", nm, bus.data_valid, bus.busy); end
    n_cmp++; if (vcount - v0 != 1) begin n_err++; $display("FAIL %s_pulses got %0d want 1", nm, vcount - v0); end
  endtask

  task automatic test_width5();
    bit bits[5] = '{1, 1, 1, 0, 1};
    for (int i = 0; i < 5; i++) begin
      send_bit(bits[i], 8, 5, 1'b1);
      n_cmp++;
      if (bus.bit_cnt !== CW'((i + 1) % 5)) begin n_err++; $display("FAIL w5_bit_cnt[%0d] got %0d want %0d", i, bus.bit_cnt, (i + 1) % 5); end
    end
    n_cmp++; if (bus.p_data !== 9'h017 || bus.par_calc !== 1'b0) begin n_err++; $display("FAIL w5_word got %h/%b want 017/0", bus.p_data, bus.par_calc); end
  endtask

  task automatic test_abort();
    logic [7:0] w = 8'h5A;
    int v0 = vcount;
    for (int i = 0; i < 3; i++) send_bit(w[i], 8, 8, 1'b1);
    n_cmp++; if (bus.busy !== 1'b1 || bus.bit_cnt !== 4'd3) begin n_err++; $display("FAIL abort_mid got busy=%b cnt=%0d want 1 3", bus.busy, bus.bit_cnt); end
    step(1'b0, 1'b0, 1'b0, 8, 7, 8, 1'b1);
    n_cmp++; if (bus.busy !== 1'b0 || bus.bit_cnt !== 4'd0) begin n_err++; $display("FAIL abort_clear got busy=%b cnt=%0d want 0 0", bus.busy, bus.bit_cnt); end
    n_cmp++; if (bus.p_data !== 9'h017 || vcount != v0) begin n_err++; $display("FAIL abort_hold got %h pulses=%0d want 017 0", bus.p_data, vcount - v0); end
    for (int i = 0; i < 8; i++) send_bit(w[i], 8, 8, 1'b1);
    n_cmp++; if (bus.p_data !== 9'h05A || vcount - v0 != 1) begin n_err++; $display("FAIL abort_fresh got %h pulses=%0d want 05A 1", bus.p_data, vcount - v0); end
  endtask

  task automatic test_cfg_change();
    logic [7:0] w = 8'hC3;
    logic [8:0] w9 = 9'h1AB;
    logic [8:0] w12 = 9'h0F6;
    int v0 = vcount;
    send_bit(w[0], 8, 8, 1'b1);
    for (int i = 1; i < 8; i++) begin
      send_bit(w[i], 8, 5, 1'b0);
      if (i == 4) begin
        n_cmp++; if (vcount != v0) begin n_err++; $display("FAIL cfg_early got %0d pulses want 0", vcount - v0); end
      end
    end
    n_cmp++; if (bus.p_data !== 9'h0C3 || vcount - v0 != 1) begin n_err++; $display("FAIL cfg_hold got %h pulses=%0d want 0C3 1", bus.p_data, vcount - v0); end
    v0 = vcount;
    for (int i = 0; i < 9; i++) begin
      send_bit(w9[i], 8, 0, 1'b1);
      if (i == 7) begin
        n_cmp++; if (vcount != v0) begin n_err++; $display("FAIL cfg0_early got %0d pulses want 0", vcount - v0); end
      end
    end
    n_cmp++; if (bus.p_data !== 9'h1AB || bus.par_calc !== 1'b0 || vcount - v0 != 1) begin n_err++; $display("FAIL cfg0_word got %h/%b pulses=%0d want 1AB/0 1", bus.p_data, bus.par_calc, vcount - v0); end
    v0 = vcount;
    for (int i = 0; i < 9; i++) send_bit(w12[i], 8, 12, 1'b1);
    n_cmp++; if (bus.p_data !== 9'h0F6 || vcount - v0 != 1) begin n_err++; $display("FAIL cfg12_word got %h pulses=%0d want 0F6 1", bus.p_data, vcount - v0); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] wa = 8'hA5;
    logic [7:0] wb = 8'h3C;
    int first_at = -1;
    int v0 = vcount;
    for (int i = 0; i < 16; i++) begin
      send_bit(i < 8 ? wa[i] : wb[i-8], 4, 8, 1'b1);
      if (bus.data_valid === 1'b1) begin
        if (first_at < 0) begin
          first_at = i;
          n_cmp++; if (bus.p_data !== 9'h0A5) begin n_err++; $display("FAIL b2b_first got %h want 0A5", bus.p_data); end
        end else begin
          n_cmp++; if (i - first_at != 8) begin n_err++; $display("FAIL b2b_spacing got %0d want 8", i - first_at); end
          n_cmp++; if (bus.p_data !== 9'h03C || bus.par_calc !== 1'b0) begin n_err++; $display("FAIL b2b_second got %h/%b want 03C/0", bus.p_data, bus.par_calc); end
        end
      end
    end
    n_cmp++; if (vcount - v0 != 2) begin n_err++; $display("FAIL b2b_pulses got %0d want 2", vcount - v0); end
    for (int i = 0; i < 3; i++) send_bit(wa[i], 4, 8, 1'b1);
    step(1'b1, 1'b1, 1'b1, 4, 3, 8, 1'b1);
    n_cmp++; if (bus.p_data !== 9'h000 || bus.busy !== 1'b0 || bus.bit_cnt !== 4'd0 || bus.par_calc !== 1'b0 || bus.data_valid !== 1'b0)
      begin n_err++; $display("FAIL midrst got p=%h busy=%b cnt=%0d par=%b v=%b want all 0", bus.p_data, bus.busy, bus.bit_cnt, bus.par_calc, bus.data_valid); end
    step(1'b0, 1'b0, 1'b0, 4, 0, 8, 1'b1);
  endtask

  task automatic test_single_bit();
    bit bits[4] = '{1, 0, 1, 1};
    // prescale=1 caps every cycle at edge_cnt 0; prescale=0 caps at edge_cnt 63
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b1, bits[i], i < 2 ? 1 : 0, i < 2 ? 0 : 63, 1, 1'b0);
      n_cmp++; if (bus.data_valid !== 1'b1 || bus.p_data !== MW'(bits[i]) || bus.par_calc !== bits[i] || bus.busy !== 1'b0)
        begin n_err++; $display("FAIL single[%0d] got v=%b p=%h par=%b busy=%b want 1 %0d %0d 0", i, bus.data_valid, bus.p_data, bus.par_calc, bus.busy, bits[i], bits[i]); end
    end
    step(1'b0, 1'b0, 1'b0, 1, 0, 1, 1'b0);
  endtask

  task automatic test_random();
    int ps = 4, db = 8, ec;
    bit lf = 1'b1, en, r;
    int shown = 0;
    for (int c = 0; c < 6000; c++) begin
      if ($urandom_range(0, 199) == 0) ps = ($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(1, 6));
      if ($urandom_range(0, 29) == 0) db = int'($urandom_range(0, 15));
      if ($urandom_range(0, 29) == 0) lf = bit'($urandom_range(0, 1));
      ec = ($urandom_range(0, 2) != 0) ? (ps + 63) % 64 : int'($urandom_range(0, 63));
      en = ($urandom_range(0, 59) != 0);
      r  = ($urandom_range(0, 999) == 0);
      step(r, en, bit'($urandom_range(0, 1)), ps, ec, db, lf);
      n_cmp++;
      if (bus.data_valid !== m_valid || bus.p_data !== MW'(m_pdata) || bus.par_calc !== m_par ||
          bus.busy !== (m_q.size() > 0) || bus.bit_cnt !== CW'(m_q.size())) begin
        n_err++;
        if (shown < 20) begin
          shown++;
          $display("FAIL rand[%0d] got v=%b p=%h par=%b busy=%b cnt=%0d want v=%b p=%h par=%b busy=%0d cnt=%0d",
                   c, bus.data_valid, bus.p_data, bus.par_calc, bus.busy, bus.bit_cnt,
                   m_valid, MW'(m_pdata), m_par, m_q.size() > 0, m_q.size());
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_frame8(1'b1, 9'h04D, "lsb8");
    test_frame8(1'b0, 9'h0B2, "msb8");
    test_width5();
    test_abort();
    test_cfg_change();
    test_back_to_back();
    test_single_bit();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
